// File: rtl/mod_pkg.sv
// mod_pkg: shared constants and helpers for the Barrett reduction pipeline.
// Holds default operand width, default modulus and the derived Barrett K and M.
package mod_pkg;

    // Default operand width; the product input is twice this wide.
    localparam int DEF_WIDTH_IN = 24;

    // Default modulus (odd, below 2^DEF_WIDTH_IN).
    localparam longint unsigned DEF_Q = 64'd8380417;

    // Smallest n with 2^n >= v.
    function automatic int clog2_u(input longint unsigned v);
        int r;
        r = 0;
        for (int i = 0; i < 63; i++) begin
            if ((64'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Barrett shift: K = 2*ceil(log2 q).
    function automatic int barrett_k(input longint unsigned q);
        return 2 * clog2_u(q);
    endfunction

    // Barrett multiplier: M = floor(2^K / q).
    function automatic longint unsigned barrett_m(
        input longint unsigned q
    );
        return (64'd1 << barrett_k(q)) / q;
    endfunction

    localparam int              DEF_K = barrett_k(DEF_Q);
    localparam longint unsigned DEF_M = barrett_m(DEF_Q);

endpackage

// File: rtl/mod_csub.sv
// mod_csub: combinational conditional subtraction, y = (a >= Q) ? a - Q : a.
// Ports: a (input, WIDTH bits), y (output, WIDTH bits).
module mod_csub
    import mod_pkg::*;
#(
    parameter int              WIDTH = DEF_WIDTH_IN + 2,
    parameter longint unsigned Q     = DEF_Q
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    localparam logic [WIDTH-1:0] QW = WIDTH'(Q);

    assign y = (a >= QW) ? a - QW : a;

endmodule

// File: rtl/mod_reduce_pipe.sv
// mod_reduce_pipe: 3-stage Barrett reduction of a signed product modulo Q.
// Ports: clk, rst_n (async, active low); in_valid/in_ready/in_p (2*WIDTH_IN,
// signed) upstream handshake; out_valid/out_ready/out_r (WIDTH_IN)/out_err
// downstream handshake. out_err flags inputs outside [0, Q*Q), out_r is 0 then.
module mod_reduce_pipe
    import mod_pkg::*;
#(
    parameter int              WIDTH_IN = DEF_WIDTH_IN,
    parameter longint unsigned Q        = DEF_Q
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [2*WIDTH_IN-1:0] in_p,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH_IN-1:0]          out_r,
    output logic                         out_err
);

    localparam int XW = 2 * WIDTH_IN;
    // r = x - t*Q lies in [0, 3Q) for in-range x, so two guard bits suffice.
    localparam int TW = WIDTH_IN + 2;
    // M < 2^(WIDTH_IN+1), so x*M fits in XW + TW bits.
    localparam int PW = XW + TW;
    localparam int K  = barrett_k(Q);

    localparam logic [PW-1:0] MP = PW'(barrett_m(Q));
    localparam logic [TW-1:0] QT = TW'(Q);
    localparam logic [XW-1:0] QQ = XW'(Q * Q);

    logic          en;
    logic          in_range;
    logic [PW-1:0] xm;

    logic          s1_v;
    logic          s1_err;
    logic [TW-1:0] s1_x;
    logic [TW-1:0] s1_t;

    logic          s2_v;
    logic          s2_err;
    logic [TW-1:0] s2_r;

    logic [TW-1:0] c1;
    logic [TW-1:0] c2;

    // One global enable: the whole pipe moves or the whole pipe holds.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Negative products have the sign bit set; the rest compare unsigned.
    assign in_range = !in_p[XW-1] && ($unsigned(in_p) < QQ);

    assign xm = PW'($unsigned(in_p)) * MP;

    // Stage valid bits and the registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v      <= 1'b0;
            s2_v      <= 1'b0;
            out_valid <= 1'b0;
            out_r     <= '0;
            out_err   <= 1'b0;
        end else if (en) begin
            s1_v      <= in_valid;
            s2_v      <= s1_v;
            out_valid <= s2_v;
            if (s2_v) begin
                out_err <= s2_err;
                out_r   <= s2_err ? '0 : WIDTH_IN'(c2);
            end
        end
    end

    // Datapath: only low TW bits of x matter for r, since r < 2^TW.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_x   <= TW'($unsigned(in_p));
            s1_t   <= TW'(xm >> K);
            s1_err <= !in_range;
            s2_r   <= s1_x - s1_t * QT;
            s2_err <= s1_err;
        end
    end

    mod_csub #(
        .WIDTH (TW),
        .Q     (Q)
    ) u_csub0 (
        .a (s2_r),
        .y (c1)
    );

    mod_csub #(
        .WIDTH (TW),
        .Q     (Q)
    ) u_csub1 (
        .a (c1),
        .y (c2)
    );

endmodule

// File: tb/tb_mod_reduce_pipe.sv
// tb_mod_reduce_pipe: directed and random checks of mod_reduce_pipe.
// Timing, boundary, stall and reset cases plus an in-order scoreboard.
module tb_mod_reduce_pipe;

    localparam int     W  = 24;
    localparam longint Q  = 64'd8380417;
    localparam longint QQ = Q * Q;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic signed [2*W-1:0] in_p;
    logic                  out_valid;
    logic                  out_ready;
    logic [W-1:0]          out_r;
    logic                  out_err;

    int           n_run  = 0;
    int           n_fail = 0;
    logic [W:0]   sb_q[$];
    logic [W:0]   ea;

    always #5 clk = ~clk;

    mod_reduce_pipe #(
        .WIDTH_IN (W),
        .Q        ($unsigned(Q))
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_p      (in_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_err   (out_err)
    );

    // Reference: plain modulo, {err, r}.
    function automatic logic [W:0] model(input longint p);
        if (p < 0 || p >= QQ) begin
            return {1'b1, {W{1'b0}}};
        end
        return {1'b0, W'(p % Q)};
    endfunction

    task automatic chk(
        input string       tag,
        input logic [63:0] got,
        input logic [63:0] exp
    );
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input longint p);
        in_valid = v;
        in_p     = (2*W)'(p);
    endtask

    // Scoreboard step at the falling edge, then advance to just after
    // the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_extra", 64'd1, 64'd0);
                end else begin
                    chk("sb_data", 64'({out_err, out_r}), 64'(sb_q[0]));
                    void'(sb_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(model(longint'(in_p)));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        longint p;
        int     sel;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_p      = '0;
        out_ready = 1'b1;

        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_r", 64'(out_r), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // 0, Q, Q-1 back-to-back: results in cycles 3, 4, 5.
        tick();
        drive(1'b1, 0);
        tick();
        chk("lat_c1_valid", 64'(out_valid), 64'd0);
        drive(1'b1, Q);
        tick();
        chk("lat_c2_valid", 64'(out_valid), 64'd0);
        drive(1'b1, Q - 1);
        tick();
        drive(1'b0, 0);
        chk("lat_c3_valid", 64'(out_valid), 64'd1);
        chk("lat_c3_r", 64'(out_r), 64'd0);
        chk("lat_c3_err", 64'(out_err), 64'd0);
        tick();
        chk("lat_c4_valid", 64'(out_valid), 64'd1);
        chk("lat_c4_r", 64'(out_r), 64'd0);
        tick();
        chk("lat_c5_valid", 64'(out_valid), 64'd1);
        chk("lat_c5_r", 64'(out_r), 64'd8380416);
        tick();
        chk("lat_c6_valid", 64'(out_valid), 64'd0);

        // Top of the contract range.
        drive(1'b1, (Q - 1) * (Q - 1));
        tick();
        drive(1'b1, QQ - 1);
        tick();
        drive(1'b0, 0);
        tick();
        chk("sq_r", 64'(out_r), 64'd1);
        chk("sq_err", 64'(out_err), 64'd0);
        tick();
        chk("qq1_r", 64'(out_r), 64'd8380416);
        chk("qq1_err", 64'(out_err), 64'd0);
        tick();

        // Out of range on both sides, then a legal one.
        drive(1'b1, -1);
        tick();
        drive(1'b1, QQ);
        tick();
        drive(1'b1, 5);
        tick();
        drive(1'b0, 0);
        chk("neg_err", 64'(out_err), 64'd1);
        chk("neg_r", 64'(out_r), 64'd0);
        tick();
        chk("qq_err", 64'(out_err), 64'd1);
        chk("qq_r", 64'(out_r), 64'd0);
        tick();
        chk("after_err", 64'(out_err), 64'd0);
        chk("after_r", 64'(out_r), 64'd5);
        tick();

        // Extremes of the signed input word, checked by the scoreboard.
        drive(1'b1, 64'h0000_7FFF_FFFF_FFFF);
        tick();
        drive(1'b1, -64'sh0000_8000_0000_0000);
        tick();
        drive(1'b1, QQ - Q);
        tick();
        drive(1'b0, 0);
        repeat (4) tick();

        // Stall with three in flight.
        out_ready = 1'b0;
        drive(1'b1, 64'd12345678901);
        tick();
        drive(1'b1, Q + 7);
        tick();
        drive(1'b1, 3 * Q + 123456);
        tick();
        drive(1'b0, 0);
        ea = model(64'd12345678901);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_r", 64'(out_r), 64'(ea[W-1:0]));
            tick();
        end
        out_ready = 1'b1;
        chk("drain_a", 64'(out_r), 64'(ea[W-1:0]));
        tick();
        chk("drain_b", 64'(out_r), 64'd7);
        tick();
        chk("drain_c", 64'(out_r), 64'd123456);
        chk("drain_c_valid", 64'(out_valid), 64'd1);
        tick();
        chk("drain_end_valid", 64'(out_valid), 64'd0);

        // Reset pulse mid-flight.
        drive(1'b1, 64'd1000);
        tick();
        drive(1'b1, 64'd2000);
        tick();
        drive(1'b1, 64'd3000);
        tick();
        drive(1'b0, 0);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_r", 64'(out_r), 64'd0);
        chk("mid_rst_err", 64'(out_err), 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_idle", 64'(out_valid), 64'd0);
            tick();
        end
        drive(1'b1, 2 * Q + 42);
        tick();
        drive(1'b0, 0);
        tick();
        chk("post_rst_c2_valid", 64'(out_valid), 64'd0);
        tick();
        chk("post_rst_first_valid", 64'(out_valid), 64'd1);
        chk("post_rst_first_r", 64'(out_r), 64'd42);
        tick();
        chk("post_rst_single", 64'(out_valid), 64'd0);

        // Random traffic and back-pressure against the reference model.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            sel       = int'($urandom_range(0, 15));
            p = longint'({$urandom, $urandom} & 64'h7FFF_FFFF_FFFF_FFFF);
            p = p % QQ;
            if (sel == 0) begin
                p = -longint'($urandom_range(1, 1000));
            end else if (sel == 1) begin
                p = QQ + longint'($urandom);
            end
            in_p = (2*W)'(p);
            tick();
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();
        chk("final_drain", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
